arashi_wbuf: RTL
================

# arashi_wbuf

Multi-thread write buffer: the write-direction counterpart of the thread read-return memory. Up to 2^THREAD_NUM_WIDTH threads request writes of one data word each. A built-in round-robin arbiter grants one thread per cycle and queues its word in a circular FIFO. The FIFO drains toward the cache over a valid/ack handshake (`mem_valid`/`mem2cache`/`cache_ack`).

## Interface
- `DATA_WIDTH`, 32, width of one data word.
- `THREAD_NUM_WIDTH`, 2, log2 of the thread count; THREAD_NUM = 1 << THREAD_NUM_WIDTH.
- `MEM_WIDTH`, 4, log2 of storage depth; usable capacity NO_MORE = (1 << MEM_WIDTH) - 1 entries.
- `clk`  input  1  clock; all logic on posedge.
- `rstn`  input  1  reset, synchronous, active-low.
- `w_ena`  input  THREAD_NUM  per-thread write request; held high until that thread's `w_ready` bit is seen.
- `data_in`  input  DATA_WIDTH*THREAD_NUM  thread t's word on bits [(t+1)*DATA_WIDTH-1 : t*DATA_WIDTH]; held stable while `w_ena[t]` is high.
- `w_ready`  output  THREAD_NUM  registered one-hot, one-cycle accept pulse.
- `mem_valid`  output  1  FIFO non-empty; `mem2cache` is valid.
- `mem2cache`  output  DATA_WIDTH  head-of-FIFO word (show-ahead).
- `cache_ack`  input  1  cache consumes head word when high together with `mem_valid`.
- `backlog`  output  MEM_WIDTH  occupied entries, wptr - rptr modulo 2^MEM_WIDTH.

## Operation
- Storage: 2^MEM_WIDTH x DATA_WIDTH array; `wptr` and `rptr` are MEM_WIDTH bits and wrap modulo 2^MEM_WIDTH. Full when backlog == NO_MORE; empty when backlog == 0.
- Arbitration: eligible[t] = w_ena[t] & ~w_ready[t]. A thread whose accept pulse is currently high is masked, which prevents a double write.
- Grant goes to the first eligible thread searching from (last_grant+1) mod THREAD_NUM upward with wrap. `last_grant` resets to THREAD_NUM-1, so thread 0 has priority first.
- Accept: at posedge with rstn=1, not full (pre-update backlog) and any eligible thread:
  - mem[wptr] <= granted thread's data_in slice; wptr <= wptr+1;
  - last_grant <= granted thread; w_ready <= 1 << granted thread.
- Otherwise w_ready <= 0. At most one accept per cycle.
- Drain: mem_valid = (backlog != 0); mem2cache = mem[rptr]. On posedge with mem_valid & cache_ack: rptr <= rptr+1. cache_ack while empty is ignored.
- Simultaneous accept and pop: both take effect; backlog unchanged.
- Full: writes are blocked even if a pop happens in the same cycle (no bypass); w_ready stays 0, requests keep waiting.
- Empty: no write-to-read bypass; an accepted word is visible after the accepting edge.
- Reset (any time, including mid-operation): wptr=rptr=0, last_grant=THREAD_NUM-1, w_ready=0, all storage zeroed. Queued words are discarded.
- Reset values of outputs: w_ready=0, mem_valid=0, mem2cache=0, backlog=0.

## Timing
- Accept latency: w_ena[t] sampled high at edge N (eligible, not full) -> w_ready[t]=1 for exactly cycle N..N+1; mem_valid=1 and backlog incremented from the same edge.
- The thread drops w_ena or changes data_in only after seeing w_ready. Minimum per-thread spacing is 2 cycles; aggregate throughput is 1 word/cycle with 2+ active threads.
- Pop: mem_valid & cache_ack at edge M -> next word (or mem_valid=0) from edge M.
- Sustained steady state: 1 accept + 1 pop per cycle, backlog constant.
- mem2cache and mem_valid depend only on registers; no combinational path from cache_ack or w_ena to any output.

## Test plan
Test plan parameters: DATA_WIDTH=8, THREAD_NUM_WIDTH=2, MEM_WIDTH=2 (capacity 3).
- Reset, then idle -> w_ready=0000, mem_valid=0, mem2cache=0x00, backlog=0; cache_ack=1 is ignored and backlog stays 0.
- Thread 2 writes 0xA5, cache_ack=0 -> w_ready=0100 for one cycle; mem_valid=1, mem2cache=0xA5, backlog=1; thread 2 is not re-granted while w_ready[2]=1.
- All four threads request with words 0x10,0x11,0x12,0x13, cache_ack=1 constantly -> grants in order 0,1,2,3 on consecutive cycles; cache receives 0x10,0x11,0x12,0x13 in order; backlog never exceeds 1.
- Threads 0 and 1 keep requesting, cache_ack=0 -> 3 accepts, then backlog=3 and w_ready=0000 while full. Pulse cache_ack for one cycle -> the write is still blocked that cycle; the next request is accepted the following cycle.
- 10 words via one thread, with pops interleaved so the pointers wrap at least twice -> output order and data match input; backlog is correct across wrap.
- Assert rstn=0 for one cycle with backlog=2 and w_ena active -> after that edge all outputs are at reset values, and the next accept goes to thread 0 first.

Source files
------------

// File: rtl/arashi_wbuf.sv
// Multi-thread write buffer: a round-robin arbiter accepts one thread word per cycle
// into a circular FIFO that drains toward the cache over a valid/ack handshake.
module arashi_wbuf #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned THREAD_NUM_WIDTH = 2,
    parameter int unsigned MEM_WIDTH        = 4
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic [(1 << THREAD_NUM_WIDTH)-1:0]         w_ena,
    input  logic [DATA_WIDTH*(1 << THREAD_NUM_WIDTH)-1:0] data_in,
    output logic [(1 << THREAD_NUM_WIDTH)-1:0]         w_ready,
    output logic                                       mem_valid,
    output logic [DATA_WIDTH-1:0]                      mem2cache,
    input  logic                                       cache_ack,
    output logic [MEM_WIDTH-1:0]                       backlog
);

    localparam int unsigned THREAD_NUM = 1 << THREAD_NUM_WIDTH;
    localparam int unsigned DEPTH      = 1 << MEM_WIDTH;
    localparam logic [MEM_WIDTH-1:0] NO_MORE = MEM_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0]       mem [DEPTH];
    logic [MEM_WIDTH-1:0]        wptr;
    logic [MEM_WIDTH-1:0]        rptr;
    logic [THREAD_NUM_WIDTH-1:0] last_grant;
    logic [THREAD_NUM_WIDTH-1:0] grant_idx;
    logic [THREAD_NUM_WIDTH-1:0] cand;
    logic                        grant_vld;
    logic [THREAD_NUM-1:0]       eligible;
    logic [THREAD_NUM-1:0]       grant_oh;
    logic [DATA_WIDTH-1:0]       words [THREAD_NUM];
    logic                        full;
    logic                        accept;
    logic                        pop;

    for (genvar t = 0; t < THREAD_NUM; t++) begin : g_split
        assign words[t] = data_in[t*DATA_WIDTH +: DATA_WIDTH];
    end

    // A thread whose accept pulse is still high is masked to avoid a double write.
    assign eligible = w_ena & ~w_ready;

    // Round-robin search starting just after the last granted thread.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= THREAD_NUM; i++) begin
            cand = last_grant + THREAD_NUM_WIDTH'(i);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_oh  = THREAD_NUM'(1) << grant_idx;
    assign backlog   = wptr - rptr;
    assign full      = (backlog == NO_MORE);
    assign mem_valid = (backlog != '0);
    assign mem2cache = mem[rptr];
    assign accept    = grant_vld & ~full;
    assign pop       = mem_valid & cache_ack;

    // Full blocks writes regardless of a same-cycle pop; no bypass in either direction.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr       <= '0;
            rptr       <= '0;
            last_grant <= THREAD_NUM_WIDTH'(THREAD_NUM - 1);
            w_ready    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[MEM_WIDTH'(i)] <= '0;
            end
        end else begin
            if (accept) begin
                mem[wptr]  <= words[grant_idx];
                wptr       <= wptr + MEM_WIDTH'(1);
                last_grant <= grant_idx;
                w_ready    <= grant_oh;
            end else begin
                w_ready    <= '0;
            end
            if (pop) begin
                rptr <= rptr + MEM_WIDTH'(1);
            end
        end
    end

endmodule
